// File: rtl/sram_ctrl.sv
// sram_ctrl: single-port controller for the 256K x 16 audio SRAM with a FIFO ring buffer in the low region plus MM access.
// Optional: define SRAM_CTRL_RR_ARB_EN for round-robin FIFO/MM arbitration; fixed priority otherwise.
module sram_ctrl #(
  parameter int P_LB_DATA_W    = 16,
  parameter int P_SRAM_ADDR_W  = 18,
  parameter int P_FF_DEPTH_W   = 16,
  parameter int P_FF_AEMPTY_TH = 64
) (
  input  logic                     clk_ir,
  input  logic                     rst_ih,
  input  logic                     sram_ff_wr_en_ih,
  input  logic [P_LB_DATA_W-1:0]   sram_ff_wr_data_id,
  output logic                     sram_ff_wr_rdy_oh,
  input  logic                     sram_ff_rd_en_ih,
  output logic                     sram_ff_rd_rdy_oh,
  output logic                     sram_ff_rd_valid_od,
  output logic [P_LB_DATA_W-1:0]   sram_ff_rd_data_od,
  output logic                     sram_ff_full_oh,
  output logic                     sram_ff_empty_oh,
  output logic                     sram_ff_aempty_oh,
  input  logic                     sram_mm_rd_en_ih,
  input  logic                     sram_mm_wr_en_ih,
  input  logic [P_SRAM_ADDR_W-1:0] sram_mm_addr_id,
  input  logic [P_LB_DATA_W-1:0]   sram_mm_wr_data_id,
  output logic                     sram_mm_rd_valid_od,
  output logic [P_LB_DATA_W-1:0]   sram_mm_rd_data_od,
  output logic                     sram_arb_mm_grant_oh,
  output logic [P_SRAM_ADDR_W-1:0] sram_addr_od,
  output logic [P_LB_DATA_W-1:0]   sram_dq_od,
  output logic                     sram_dq_oe_oh,
  input  logic [P_LB_DATA_W-1:0]   sram_dq_id,
  output logic                     sram_ce_ol,
  output logic                     sram_we_ol,
  output logic                     sram_oe_ol
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WR_SETUP  = 3'd1;
  localparam logic [2:0] ST_WR_PULSE  = 3'd2;
  localparam logic [2:0] ST_WR_HOLD   = 3'd3;
  localparam logic [2:0] ST_RD_SETUP  = 3'd4;
  localparam logic [2:0] ST_RD_SAMPLE = 3'd5;

  localparam logic [P_FF_DEPTH_W:0] OCC_FULL   = {1'b1, {P_FF_DEPTH_W{1'b0}}};
  localparam logic [P_FF_DEPTH_W:0] OCC_AEMPTY = (P_FF_DEPTH_W+1)'(P_FF_AEMPTY_TH);

  logic [2:0]                state_reg;
  logic [P_FF_DEPTH_W:0]     occ_reg;
  logic [P_FF_DEPTH_W-1:0]   wr_ptr_reg;
  logic [P_FF_DEPTH_W-1:0]   rd_ptr_reg;
  logic                      push_pend_reg;
  logic [P_LB_DATA_W-1:0]    push_data_reg;
  logic [P_FF_DEPTH_W-1:0]   push_addr_reg;
  logic                      pop_pend_reg;
  logic [P_FF_DEPTH_W-1:0]   pop_addr_reg;
  logic                      rd_is_mm_reg;
  logic [P_SRAM_ADDR_W-1:0]  addr_reg;
  logic [P_LB_DATA_W-1:0]    dq_reg;
  logic                      dq_oe_reg;
  logic                      ce_reg;
  logic                      we_reg;
  logic                      oe_reg;
  logic                      grant_reg;
  logic                      ff_rd_valid_reg;
  logic [P_LB_DATA_W-1:0]    ff_rd_data_reg;
  logic                      mm_rd_valid_reg;
  logic [P_LB_DATA_W-1:0]    mm_rd_data_reg;

  logic full, empty, push_acc, pop_acc;
  logic mm_rd_req, mm_req, ff_req, pick_mm;
  logic sel_push, sel_pop, sel_mm_wr, sel_mm_rd;

  assign full     = (occ_reg == OCC_FULL);
  assign empty    = (occ_reg == '0);
  assign push_acc = sram_ff_wr_en_ih & ~push_pend_reg & ~full;
  assign pop_acc  = sram_ff_rd_en_ih & ~pop_pend_reg & ~empty;

  // The initiator releases rd_en one cycle after rd_valid, so that cycle's request is stale.
  assign mm_rd_req = sram_mm_rd_en_ih & ~mm_rd_valid_reg;
  assign mm_req    = sram_mm_wr_en_ih | mm_rd_req;
  assign ff_req    = push_pend_reg | pop_pend_reg;

`ifdef SRAM_CTRL_RR_ARB_EN
  logic last_mm_reg;
  assign pick_mm = mm_req & (~ff_req | ~last_mm_reg);

  // Resets as if MM went last, so the first contended slot goes to the FIFO.
  always_ff @(posedge clk_ir) begin
    if (rst_ih) begin
      last_mm_reg <= 1'b1;
    end else if (state_reg == ST_IDLE && (ff_req | mm_req)) begin
      last_mm_reg <= pick_mm;
    end
  end
`else
  assign pick_mm = mm_req & ~ff_req;
`endif

  assign sel_push  = ~pick_mm & push_pend_reg;
  assign sel_pop   = ~pick_mm & ~push_pend_reg & pop_pend_reg;
  assign sel_mm_wr = pick_mm & sram_mm_wr_en_ih;
  assign sel_mm_rd = pick_mm & ~sram_mm_wr_en_ih;

  always_ff @(posedge clk_ir) begin
    if (rst_ih) begin
      state_reg       <= ST_IDLE;
      occ_reg         <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      push_pend_reg   <= 1'b0;
      push_data_reg   <= '0;
      push_addr_reg   <= '0;
      pop_pend_reg    <= 1'b0;
      pop_addr_reg    <= '0;
      rd_is_mm_reg    <= 1'b0;
      addr_reg        <= '0;
      dq_reg          <= '0;
      dq_oe_reg       <= 1'b0;
      ce_reg          <= 1'b1;
      we_reg          <= 1'b1;
      oe_reg          <= 1'b1;
      grant_reg       <= 1'b0;
      ff_rd_valid_reg <= 1'b0;
      ff_rd_data_reg  <= '0;
      mm_rd_valid_reg <= 1'b0;
      mm_rd_data_reg  <= '0;
    end else begin
      grant_reg       <= 1'b0;
      ff_rd_valid_reg <= 1'b0;
      mm_rd_valid_reg <= 1'b0;

      if (push_acc) begin
        push_pend_reg <= 1'b1;
        push_data_reg <= sram_ff_wr_data_id;
        push_addr_reg <= wr_ptr_reg;
        wr_ptr_reg    <= wr_ptr_reg + 1'b1;
      end
      if (pop_acc) begin
        pop_pend_reg <= 1'b1;
        pop_addr_reg <= rd_ptr_reg;
        rd_ptr_reg   <= rd_ptr_reg + 1'b1;
      end
      if (push_acc & ~pop_acc) begin
        occ_reg <= occ_reg + 1'b1;
      end else if (pop_acc & ~push_acc) begin
        occ_reg <= occ_reg - 1'b1;
      end

      case (state_reg)
        ST_IDLE: begin
          if (sel_push) begin
            push_pend_reg <= 1'b0;
            addr_reg      <= P_SRAM_ADDR_W'(push_addr_reg);
            dq_reg        <= push_data_reg;
            ce_reg        <= 1'b0;
            dq_oe_reg     <= 1'b1;
            state_reg     <= ST_WR_SETUP;
          end else if (sel_pop) begin
            pop_pend_reg <= 1'b0;
            addr_reg     <= P_SRAM_ADDR_W'(pop_addr_reg);
            ce_reg       <= 1'b0;
            oe_reg       <= 1'b0;
            rd_is_mm_reg <= 1'b0;
            state_reg    <= ST_RD_SETUP;
          end else if (sel_mm_wr) begin
            addr_reg  <= sram_mm_addr_id;
            dq_reg    <= sram_mm_wr_data_id;
            ce_reg    <= 1'b0;
            dq_oe_reg <= 1'b1;
            grant_reg <= 1'b1;
            state_reg <= ST_WR_SETUP;
          end else if (sel_mm_rd) begin
            addr_reg     <= sram_mm_addr_id;
            ce_reg       <= 1'b0;
            oe_reg       <= 1'b0;
            rd_is_mm_reg <= 1'b1;
            grant_reg    <= 1'b1;
            state_reg    <= ST_RD_SETUP;
          end
        end
        ST_WR_SETUP: begin
          we_reg    <= 1'b0;
          state_reg <= ST_WR_PULSE;
        end
        ST_WR_PULSE: begin
          we_reg    <= 1'b1;
          state_reg <= ST_WR_HOLD;
        end
        ST_WR_HOLD: begin
          ce_reg    <= 1'b1;
          dq_oe_reg <= 1'b0;
          state_reg <= ST_IDLE;
        end
        ST_RD_SETUP: begin
          state_reg <= ST_RD_SAMPLE;
        end
        ST_RD_SAMPLE: begin
          ce_reg <= 1'b1;
          oe_reg <= 1'b1;
          if (rd_is_mm_reg) begin
            mm_rd_data_reg  <= sram_dq_id;
            mm_rd_valid_reg <= 1'b1;
          end else begin
            ff_rd_data_reg  <= sram_dq_id;
            ff_rd_valid_reg <= 1'b1;
          end
          state_reg <= ST_IDLE;
        end
        default: begin
          ce_reg    <= 1'b1;
          we_reg    <= 1'b1;
          oe_reg    <= 1'b1;
          dq_oe_reg <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign sram_ff_wr_rdy_oh    = ~push_pend_reg;
  assign sram_ff_rd_rdy_oh    = ~pop_pend_reg;
  assign sram_ff_rd_valid_od  = ff_rd_valid_reg;
  assign sram_ff_rd_data_od   = ff_rd_data_reg;
  assign sram_ff_full_oh      = full;
  assign sram_ff_empty_oh     = empty;
  assign sram_ff_aempty_oh    = (occ_reg <= OCC_AEMPTY);
  assign sram_mm_rd_valid_od  = mm_rd_valid_reg;
  assign sram_mm_rd_data_od   = mm_rd_data_reg;
  assign sram_arb_mm_grant_oh = grant_reg;
  assign sram_addr_od         = addr_reg;
  assign sram_dq_od           = dq_reg;
  assign sram_dq_oe_oh        = dq_oe_reg;
  assign sram_ce_ol           = ce_reg;
  assign sram_we_ol           = we_reg;
  assign sram_oe_ol           = oe_reg;

endmodule
